// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared constants, slot record and latency helper for the SPU issue controller
package spu_pkg;

  localparam int REGBITS = 7;
  localparam int LATBITS = 3;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  localparam int LAT_FX = 2;
  localparam int LAT_LS = 6;

  typedef struct packed {
    logic               valid;
    logic               pipe;
    logic [REGBITS-1:0] rt;
    logic [LATBITS-1:0] cnt;
  } slot_t;

  // A zero latency is treated as a single-cycle operation.
  function automatic logic [LATBITS-1:0] eff_lat(input logic [LATBITS-1:0] lat);
    return (lat == '0) ? LATBITS'(1) : lat;
  endfunction

endpackage

// File: rtl/spu_sb_slot.sv
// rtl/spu_sb_slot.sv - one scoreboard entry: load, countdown, write-back match and hazard compares
module spu_sb_slot
  import spu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               load_pipe,
  input  logic [REGBITS-1:0] load_rt,
  input  logic [LATBITS-1:0] load_lat,
  input  logic [REGBITS-1:0] chk_ra,
  input  logic [REGBITS-1:0] chk_rb,
  input  logic [REGBITS-1:0] chk_rt,
  input  logic               chk_pipe,
  input  logic [LATBITS-1:0] chk_lat,
  output logic               valid,
  output logic               pipe,
  output logic [REGBITS-1:0] rt,
  output logic               wb,
  output logic               hit_ra,
  output logic               hit_rb,
  output logic               hit_rt,
  output logic               hit_port
);

  slot_t cur;
  logic  pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= '0;
    end else if (load) begin
      cur <= '{valid: 1'b1, pipe: load_pipe, rt: load_rt, cnt: eff_lat(load_lat)};
    end else if (cur.valid) begin
      if (cur.cnt == LATBITS'(1)) cur <= '0;
      else                         cur.cnt <= cur.cnt - 1'b1;
    end
  end

  // The final cycle writes through the register file, so it no longer blocks readers.
  assign pending  = cur.valid && (cur.cnt > LATBITS'(1));
  assign wb       = cur.valid && (cur.cnt == LATBITS'(1));
  assign hit_ra   = pending && (cur.rt == chk_ra);
  assign hit_rb   = pending && (cur.rt == chk_rb);
  assign hit_rt   = pending && (cur.rt == chk_rt);
  assign hit_port = cur.valid && (cur.pipe == chk_pipe) &&
                    ({1'b0, cur.cnt} == ({1'b0, eff_lat(chk_lat)} + (LATBITS+1)'(1)));

  assign valid = cur.valid;
  assign pipe  = cur.pipe;
  assign rt    = cur.rt;

endmodule

// File: rtl/spu_issue_ctrl.sv
// rtl/spu_issue_ctrl.sv - single-issue SPU scheduler with slot scoreboard and per-pipe write-back
module spu_issue_ctrl
  import spu_pkg::PIPE_EVEN;
#(
  parameter int REGBITS = 7,
  parameter int LATBITS = 3,
  parameter int DEPTH   = 8,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_pipe,
  input  logic [REGBITS-1:0] in_ra,
  input  logic [REGBITS-1:0] in_rb,
  input  logic               in_use_ra,
  input  logic               in_use_rb,
  input  logic [REGBITS-1:0] in_rt,
  input  logic               in_wr_rt,
  input  logic [LATBITS-1:0] in_lat,
  input  logic [2:0]         in_cont,
  input  logic               flush,
  output logic               ep_issue,
  output logic               op_issue,
  output logic [REGBITS-1:0] iss_ra,
  output logic [REGBITS-1:0] iss_rb,
  output logic [REGBITS-1:0] iss_rt,
  output logic [2:0]         iss_cont,
  output logic               ep_wb_en,
  output logic               op_wb_en,
  output logic [REGBITS-1:0] ep_wb_rt,
  output logic [REGBITS-1:0] op_wb_rt,
  output logic               busy,
  output logic [CNTBITS-1:0] stall_cnt
);

  logic [DEPTH-1:0]   s_valid, s_pipe, s_wb;
  logic [DEPTH-1:0]   s_hit_ra, s_hit_rb, s_hit_rt, s_hit_port;
  logic [DEPTH-1:0]   s_load, free_oh;
  logic [REGBITS-1:0] s_rt [DEPTH];
  logic               found, hazard, accept;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    spu_sb_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (s_load[i]),
      .load_pipe(in_pipe),
      .load_rt  (in_rt),
      .load_lat (in_lat),
      .chk_ra   (in_ra),
      .chk_rb   (in_rb),
      .chk_rt   (in_rt),
      .chk_pipe (in_pipe),
      .chk_lat  (in_lat),
      .valid    (s_valid[i]),
      .pipe     (s_pipe[i]),
      .rt       (s_rt[i]),
      .wb       (s_wb[i]),
      .hit_ra   (s_hit_ra[i]),
      .hit_rb   (s_hit_rb[i]),
      .hit_rt   (s_hit_rt[i]),
      .hit_port (s_hit_port[i])
    );
  end

  // Lowest-index free slot; a slot in its write-back cycle is still occupied.
  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!s_valid[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign hazard = (in_use_ra && |s_hit_ra) ||
                  (in_use_rb && |s_hit_rb) ||
                  (in_wr_rt && (|s_hit_rt || |s_hit_port || !found));
  assign in_ready = !flush && !hazard;
  assign accept   = in_valid && in_ready;
  assign s_load   = (accept && in_wr_rt) ? free_oh : '0;
  assign busy     = |s_valid;

  always_comb begin
    ep_wb_en = 1'b0;
    op_wb_en = 1'b0;
    ep_wb_rt = '0;
    op_wb_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s_wb[i]) begin
        if (s_pipe[i] == PIPE_EVEN) begin
          ep_wb_en = 1'b1;
          ep_wb_rt = ep_wb_rt | s_rt[i];
        end else begin
          op_wb_en = 1'b1;
          op_wb_rt = op_wb_rt | s_rt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ep_issue <= 1'b0;
      op_issue <= 1'b0;
      iss_ra   <= '0;
      iss_rb   <= '0;
      iss_rt   <= '0;
      iss_cont <= '0;
    end else begin
      ep_issue <= accept && (in_pipe == PIPE_EVEN);
      op_issue <= accept && (in_pipe != PIPE_EVEN);
      if (accept) begin
        iss_ra   <= in_ra;
        iss_rb   <= in_rb;
        iss_rt   <= in_rt;
        iss_cont <= in_cont;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// tb/tb_spu_issue_ctrl.sv - directed and randomized bench against an in-flight list reference model
module tb_spu_issue_ctrl;
  import spu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, in_pipe, in_use_ra, in_use_rb, in_wr_rt, flush;
  logic [6:0]  in_ra, in_rb, in_rt, iss_ra, iss_rb, iss_rt, ep_wb_rt, op_wb_rt;
  logic [2:0]  in_lat, in_cont, iss_cont;
  logic        ep_issue, op_issue, ep_wb_en, op_wb_en, busy;
  logic [15:0] stall_cnt;

  spu_issue_ctrl #(.REGBITS(7), .LATBITS(3), .DEPTH(8), .CNTBITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pipe(in_pipe),
    .in_ra(in_ra), .in_rb(in_rb), .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_rt(in_rt),
    .in_wr_rt(in_wr_rt), .in_lat(in_lat), .in_cont(in_cont), .flush(flush),
    .ep_issue(ep_issue), .op_issue(op_issue), .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rt(iss_rt),
    .iss_cont(iss_cont), .ep_wb_en(ep_wb_en), .op_wb_en(op_wb_en), .ep_wb_rt(ep_wb_rt),
    .op_wb_rt(op_wb_rt), .busy(busy), .stall_cnt(stall_cnt)
  );

  // In-flight writer: pipe, destination and the absolute cycle of its write-back.
  typedef struct {
    bit       pipe;
    bit [6:0] rt;
    int       wb;
  } flight_t;

  flight_t  fl[$];
  int       cyc, checks, errors, exp_stall;
  bit       exp_ep_iss, exp_op_iss;
  bit [6:0] exp_ra, exp_rb, exp_rt;
  bit [2:0] exp_cont;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input bit [2:0] l);
    return (l == 0) ? 1 : int'(l);
  endfunction

  function automatic bit model_ready();
    int L    = eff(in_lat);
    int live = 0;
    if (flush) return 1'b0;
    foreach (fl[i]) begin
      if (fl[i].wb >= cyc) live++;
      if (fl[i].wb > cyc) begin
        if (in_use_ra && in_ra == fl[i].rt) return 1'b0;
        if (in_use_rb && in_rb == fl[i].rt) return 1'b0;
        if (in_wr_rt && in_rt == fl[i].rt)  return 1'b0;
      end
      if (in_wr_rt && fl[i].pipe == in_pipe && fl[i].wb == cyc + L) return 1'b0;
    end
    if (in_wr_rt && live >= 8) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_in(input bit v, input bit p, input bit [6:0] ra, input bit [6:0] rb,
                        input bit ura, input bit urb, input bit [6:0] rt, input bit wr,
                        input bit [2:0] lat);
    in_valid = v; in_pipe = p; in_ra = ra; in_rb = rb; in_use_ra = ura; in_use_rb = urb;
    in_rt = rt; in_wr_rt = wr; in_lat = lat; in_cont = 3'($urandom);
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 3'd1);
  endtask

  // One clock: compare mid-cycle, then advance the model across the edge.
  task automatic step();
    flight_t  keep[$];
    bit       r, ew, ow;
    bit [6:0] ert, ort;
    ew = 0; ow = 0; ert = 0; ort = 0;
    #3;
    foreach (fl[i]) if (fl[i].wb >= cyc) keep.push_back(fl[i]);
    fl = keep;
    foreach (fl[i]) begin
      if (fl[i].wb == cyc) begin
        if (fl[i].pipe) begin ow = 1; ort = fl[i].rt; end
        else            begin ew = 1; ert = fl[i].rt; end
      end
    end
    r = model_ready();
    chk("in_ready", in_ready, r);
    chk("ep_wb_en", ep_wb_en, ew);
    chk("op_wb_en", op_wb_en, ow);
    if (ew) chk("ep_wb_rt", ep_wb_rt, ert);
    if (ow) chk("op_wb_rt", op_wb_rt, ort);
    chk("busy", busy, fl.size() != 0);
    chk("ep_issue", ep_issue, exp_ep_iss);
    chk("op_issue", op_issue, exp_op_iss);
    if (exp_ep_iss || exp_op_iss) begin
      chk("iss_ra", iss_ra, exp_ra);
      chk("iss_rb", iss_rb, exp_rb);
      chk("iss_rt", iss_rt, exp_rt);
      chk("iss_cont", iss_cont, exp_cont);
    end
    chk("stall_cnt", stall_cnt, exp_stall);
    exp_ep_iss = in_valid && r && !in_pipe;
    exp_op_iss = in_valid && r && in_pipe;
    if (in_valid && r) begin
      exp_ra = in_ra; exp_rb = in_rb; exp_rt = in_rt; exp_cont = in_cont;
      if (in_wr_rt) fl.push_back('{in_pipe, in_rt, cyc + eff(in_lat)});
    end
    if (in_valid && !r && exp_stall < 65535) exp_stall++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    idle();
    repeat (10) step();
  endtask

  initial begin
    int base;
    checks = 0; errors = 0; cyc = 0; exp_stall = 0;
    exp_ep_iss = 0; exp_op_iss = 0;
    flush = 1'b0;
    reset = 1'b0;
    set_in(1'b1, PIPE_EVEN, 7'd1, 7'd2, 1'b0, 1'b0, 7'd5, 1'b1, 3'(LAT_FX));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ep_issue", ep_issue, 0);
    chk("rst_op_issue", op_issue, 0);
    chk("rst_ep_wb_en", ep_wb_en, 0);
    chk("rst_op_wb_en", op_wb_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_iss_rt", iss_rt, 0);
    reset = 1'b1;

    step();
    idle();
    chk("first_issue", ep_issue, 1);
    step();
    chk("first_wb_en", ep_wb_en, 1);
    chk("first_wb_rt", ep_wb_rt, 5);
    drain();

    // RAW against a long-latency writer
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd10, 1'b1, 3'(LAT_LS));
    step();
    base = exp_stall;
    set_in(1'b1, PIPE_ODD, 7'd10, 7'd3, 1'b1, 1'b0, 7'd11, 1'b0, 3'd2);
    for (int k = 0; k < 20; k++) begin
      bit rr;
      rr = model_ready();
      step();
      if (rr) break;
    end
    chk("raw_stall_cnt", stall_cnt, base + 5);
    drain();

    // write-back port collision, then the same op on the other pipe
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd20, 1'b1, 3'd6);
    step();
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd21, 1'b1, 3'd5);
    #2;
    chk("port_coll_refused", in_ready, 0);
    in_pipe = PIPE_ODD;
    step();
    idle();
    repeat (4) step();
    chk("coll_ep_wb_en", ep_wb_en, 1);
    chk("coll_op_wb_en", op_wb_en, 1);
    chk("coll_ep_wb_rt", ep_wb_rt, 20);
    chk("coll_op_wb_rt", op_wb_rt, 21);
    drain();

    // eight back-to-back lat-7 writers followed by a ninth
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 1'(k), 7'd0, 7'd0, 1'b0, 1'b0, 7'(30 + k), 1'b1, 3'd7);
      step();
    end
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd40, 1'b1, 3'd7);
    step();
    chk("full_busy", busy, 1);
    drain();

    // asynchronous reset with three writers in flight
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd50, 1'b1, 3'd6);
    step();
    set_in(1'b1, PIPE_ODD, 7'd0, 7'd0, 1'b0, 1'b0, 7'd51, 1'b1, 3'd6);
    step();
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd52, 1'b1, 3'd6);
    step();
    idle();
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ep_wb_en", ep_wb_en, 0);
    chk("mid_rst_op_wb_en", op_wb_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fl.delete();
    exp_stall = 0; exp_ep_iss = 0; exp_op_iss = 0;
    repeat (8) step();

    // zero latency and flush
    set_in(1'b1, PIPE_EVEN, 7'd0, 7'd0, 1'b0, 1'b0, 7'd60, 1'b1, 3'd0);
    step();
    idle();
    chk("lat0_wb_en", ep_wb_en, 1);
    chk("lat0_wb_rt", ep_wb_rt, 60);
    set_in(1'b1, PIPE_ODD, 7'd0, 7'd0, 1'b0, 1'b0, 7'd61, 1'b1, 3'd3);
    step();
    set_in(1'b1, PIPE_EVEN, 7'd1, 7'd2, 1'b0, 1'b0, 7'd62, 1'b1, 3'd2);
    flush = 1'b1;
    base = exp_stall;
    #2;
    chk("flush_ready", in_ready, 0);
    repeat (3) step();
    chk("flush_stall_cnt", stall_cnt, base + 3);
    flush = 1'b0;
    drain();

    // random traffic over a small register window to provoke hazards
    repeat (400) begin
      set_in(1'($urandom % 4 != 0), 1'($urandom), 7'($urandom % 8), 7'($urandom % 8),
             1'($urandom), 1'($urandom), 7'($urandom % 8), 1'($urandom % 4 != 0),
             3'($urandom));
      flush = ($urandom % 10 == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
